// File: rtl/skinny_inv_sbox8_dom1_dep_hs_if.sv
// Handshake bundle for the masked SKINNY-128 inverse S-box.
// Input side: shares + randomness. Output side: result shares.
interface skinny_inv_sbox8_dom1_dep_hs_if #(
  parameter int RAND_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        si1;
  logic [7:0]        si0;
  logic [RAND_W-1:0] r;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        bo1;
  logic [7:0]        bo0;

  modport master (
    output in_valid, si1, si0, r, out_ready,
    input  in_ready, out_valid, bo1, bo0
  );

  modport slave (
    input  in_valid, si1, si0, r, out_ready,
    output in_ready, out_valid, bo1, bo0
  );
endinterface

// File: rtl/skinny_inv_sbox8_dom1_dep_hs.sv
// 2-share DOM-dep SKINNY-128 inverse S-box, 4 registered layers.
// Accept -> L1..L4 -> DONE, valid/ready on both sides.
module skinny_inv_sbox8_dom1_dep_hs #(
  parameter bit ZERO_IDLE = 1'b1,
  parameter int RAND_W    = 16
) (
  input  logic clk,
  input  logic rst,
  skinny_inv_sbox8_dom1_dep_hs_if.slave io,
  output logic busy
);

  if (RAND_W != 16) begin : g_rand_w_chk
    $error("RAND_W must be 16");
  end

  typedef enum logic [2:0] {
    IDLE, L1, L2, L3, L4, DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  w1;
  logic [7:0]  w0;
  logic [15:0] rr;
  logic [7:0]  o1;
  logic [7:0]  o0;
  logic [3:0]  m_cur;
  logic [15:0] lo;

  // masked NOR-xor: share 0 carries the complement of a and b
  function automatic logic [1:0] dom_nor(
    input logic       a1, a0,
    input logic       b1, b0,
    input logic       z1, z0,
    input logic [1:0] m
  );
    logic na0;
    logic nb0;
    logic q1;
    logic q0;
    na0 = ~a0;
    nb0 = ~b0;
    q0  = (na0 & nb0) ^ (na0 & b1) ^ m[0] ^ m[1];
    q1  = (a1 & b1) ^ (a1 & nb0) ^ m[0] ^ m[1];
    return {q1 ^ z1, q0 ^ z0};
  endfunction

  // two independent gates of one layer: bit4 and bit0
  function automatic logic [15:0] layer(
    input logic [7:0] x1,
    input logic [7:0] x0,
    input logic [3:0] m
  );
    logic [7:0] y1;
    logic [7:0] y0;
    logic [1:0] g4;
    logic [1:0] g0;
    g4 = dom_nor(x1[7], x0[7], x1[6], x0[6],
                 x1[4], x0[4], m[1:0]);
    g0 = dom_nor(x1[3], x0[3], x1[2], x0[2],
                 x1[0], x0[0], m[3:2]);
    y1 = x1;
    y0 = x0;
    y1[4] = g4[1];
    y0[4] = g4[0];
    y1[0] = g0[1];
    y0[0] = g0[0];
    return {y1, y0};
  endfunction

  // inverse of the forward inter-round bit permutation
  function automatic logic [7:0] pinv(input logic [7:0] y);
    return {y[5], y[4], y[0], y[3],
            y[1], y[7], y[6], y[2]};
  endfunction

  // undo the final bit1/bit2 swap of the forward box
  function automatic logic [7:0] swp(input logic [7:0] y);
    return {y[7:3], y[1], y[2], y[0]};
  endfunction

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (io.in_valid) state_nx = L1;
      L1:   state_nx = L2;
      L2:   state_nx = L3;
      L3:   state_nx = L4;
      L4:   state_nx = DONE;
      DONE: if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
    busy         = (state != IDLE);
    io.bo1       = o1;
    io.bo0       = o0;
  end

  // randomness slice for the layer being evaluated
  always_comb begin
    m_cur = rr[3:0];
    unique case (state)
      L2:      m_cur = rr[7:4];
      L3:      m_cur = rr[11:8];
      L4:      m_cur = rr[15:12];
      default: m_cur = rr[3:0];
    endcase
    lo = layer(w1, w0, m_cur);
  end

  // capture, layer registers and output shares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1 <= '0;
      w0 <= '0;
      rr <= '0;
      o1 <= '0;
      o0 <= '0;
    end else begin
      unique case (state)
        IDLE: if (io.in_valid) begin
          w1 <= swp(io.si1);
          w0 <= swp(io.si0);
          rr <= 16'(io.r);
        end
        L1, L2, L3: begin
          w1 <= pinv(lo[15:8]);
          w0 <= pinv(lo[7:0]);
        end
        L4: begin
          o1 <= lo[15:8];
          o0 <= lo[7:0];
        end
        DONE: if (io.out_ready && ZERO_IDLE) begin
          o1 <= '0;
          o0 <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_inv_sbox8_dom1_dep_hs.sv
// Bench for the masked SKINNY-128 inverse S-box.
// Reference table built from an independent forward model.
module tb_skinny_inv_sbox8_dom1_dep_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] inv_tab [256];

  skinny_inv_sbox8_dom1_dep_hs_if #(.RAND_W(16)) bus ();

  skinny_inv_sbox8_dom1_dep_hs #(
    .ZERO_IDLE(1'b1),
    .RAND_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus.slave),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fwd(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int k = 0; k < 4; k++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (k < 3)
        x = {x[2], x[1], x[7], x[6],
             x[4], x[0], x[3], x[5]};
    end
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [7:0] x1,
                        input logic [7:0] x0,
                        input logic [15:0] rv);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    bus.si1 = x1;
    bus.si0 = x0;
    bus.r = rv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit scr, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      if (scr) begin
        bus.si1 = 8'($urandom);
        bus.si0 = 8'($urandom);
        bus.r = 16'($urandom);
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic release_out;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic txn(input logic [7:0] x,
                     input bit scr,
                     output logic [7:0] y,
                     output int lat);
    logic [7:0] m;
    m = 8'($urandom);
    accept(m, x ^ m, 16'($urandom));
    wait_valid(scr, lat);
    y = bus.bo1 ^ bus.bo0;
    release_out();
  endtask

  initial begin
    logic [7:0] y;
    logic [7:0] b1;
    logic [7:0] b0;
    int lat;
    for (int v = 0; v < 256; v++) inv_tab[fwd(8'(v))] = 8'(v);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.si1 = '0;
    bus.si0 = '0;
    bus.r = '0;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bo", {16'd0, bus.bo1, bus.bo0}, 32'd0);

    accept(8'h00, 8'h65, 16'h0000);
    chk("busy_run", 32'(busy), 32'd1);
    chk("in_ready_run", 32'(bus.in_ready), 32'd0);
    wait_valid(1'b0, lat);
    chk("lat_first", 32'(lat), 32'd5);
    chk("first_65", 32'(bus.bo1 ^ bus.bo0), 32'h00);
    release_out();
    chk("zero_after", {16'd0, bus.bo1, bus.bo0}, 32'd0);
    chk("ov_after", 32'(bus.out_valid), 32'd0);
    chk("ir_after", 32'(bus.in_ready), 32'd1);

    txn(8'h4c, 1'b0, y, lat);
    chk("spot_4c", 32'(y), 32'h01);
    txn(8'h6a, 1'b0, y, lat);
    chk("spot_6a", 32'(y), 32'h02);
    txn(8'hff, 1'b0, y, lat);
    chk("spot_ff", 32'(y), 32'hff);

    for (int x = 0; x < 256; x++) begin
      txn(8'(x), 1'b0, y, lat);
      chk("exh", 32'(y), 32'(inv_tab[x]));
      chk("exh_lat", 32'(lat), 32'd5);
    end

    for (int v = 0; v < 256; v++) begin
      txn(fwd(8'(v)), 1'b0, y, lat);
      chk("round_trip", 32'(y), 32'(v));
    end

    accept(8'h3c, 8'h3c ^ 8'h6a, 16'hbeef);
    wait_valid(1'b0, lat);
    b1 = bus.bo1;
    b0 = bus.bo0;
    chk("bp_val", 32'(b1 ^ b0), 32'h02);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.si1 = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_bo1", 32'(bus.bo1), 32'(b1));
      chk("bp_bo0", 32'(bus.bo0), 32'(b0));
      chk("bp_ov", 32'(bus.out_valid), 32'd1);
      chk("bp_ir", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out();
    chk("bp_zero", {16'd0, bus.bo1, bus.bo0}, 32'd0);

    txn(8'h4c, 1'b1, y, lat);
    chk("scr_4c", 32'(y), 32'h01);
    chk("scr_lat", 32'(lat), 32'd5);
    txn(8'hc3, 1'b1, y, lat);
    chk("scr_c3", 32'(y), 32'(inv_tab[8'hc3]));

    bus.out_ready = 1'b1;
    accept(8'h55, 8'h55 ^ 8'hff, 16'h1234);
    wait_valid(1'b0, lat);
    chk("early_rdy_lat", 32'(lat), 32'd5);
    chk("early_rdy_val", 32'(bus.bo1 ^ bus.bo0), 32'hff);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("early_rdy_idle", 32'(bus.in_ready), 32'd1);

    accept(8'ha5, 8'ha5 ^ 8'h4c, 16'h5a5a);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ir", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_quiet", {15'd0, bus.out_valid, bus.bo1, bus.bo0}, 32'd0);
    end
    txn(8'h65, 1'b0, y, lat);
    chk("post_rst_65", 32'(y), 32'h00);
    chk("post_rst_lat", 32'(lat), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/skinny_inv_sbox8_dom1_dep_hs.md
Name: skinny_inv_sbox8_dom1_dep_hs

Overview:
First-order masked (2-share, DOM-dep) SKINNY-128 inverse 8-bit S-box, for decryption and tag-inversion paths.
- Inverse counterpart of the forward masked sbox8.
- Captures shares and randomness through a valid/ready handshake, so the upstream datapath need not hold inputs stable.
- Evaluates the 8 inverse nonlinear gates over 4 rising-edge-registered layers.
- Presents registered output shares with a valid/ready handshake.

Parameters:
- ZERO_IDLE, 1, when 1 bo1/bo0 are driven to 0 whenever out_valid=0; when 0 they hold the last result.
- RAND_W, 16, refresh-mask width: 2 bits per gate, 8 gates. Fixed; any other value is a synthesis error.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  si1/si0/r are valid
- in_ready  output  1  block can accept a new input
- si1  input  8  input share 1
- si0  input  8  input share 0
- r  input  RAND_W  fresh refresh randomness, sampled with the inputs
- out_valid  output  1  bo1/bo0 hold a valid result
- out_ready  input  1  downstream accepts the result
- bo1  output  8  output share 1
- bo0  output  8  output share 0
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all share, randomness and layer registers cleared to 0. Outputs in reset: in_ready=1, out_valid=0, bo1=bo0=0, busy=0.
- Function: (bo1^bo0) = S8inv(si1^si0), where S8inv is the standard SKINNY-128 inverse S-box.
- Each gate computes f = ~(a|b) ^ z as a DOM-dep masked gate, using a 2-bit slice of r.
- Gate order and bit wiring are the exact reverse of the forward sbox8.
- Gate dependency depth is 4, grouped into layers L1..L4.
- Share domains are never combined unregistered across layers: every layer's outputs are registered before the next layer consumes them.
- FSM states: IDLE, L1, L2, L3, L4, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge: register si1, si0, r; go to L1.
- L1..L4:
  - One cycle each; layer k gate outputs are registered at the end of Lk.
  - in_ready=0; in_valid ignored.
- After L4: go to DONE; out_valid=1 with bo1/bo0 from the layer registers.
  - Latency: accept edge to out_valid high = 5 rising edges.
- DONE:
  - Outputs held stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle; go to IDLE. If ZERO_IDLE=1, bo shares are zeroed.
  - No same-cycle re-accept: in_ready=0 in DONE.
  - Minimum initiation interval: 6 cycles.
- The captured r is used for the whole evaluation; changes on the r input after the accept edge have no effect.
- rst asserted mid-operation: immediate return to reset values; the partial result is discarded and never appears on bo.
- in_valid held high continuously: one accept per IDLE visit only.
- out_ready high before out_valid: no effect until DONE.
- Both shares are registered at the output; no combinational path from si*/r to bo*.

Test Plan:
- Reset, then in_valid with si0=0x65, si1=0x00, r=0 -> out_valid after 5 edges; bo1^bo0=0x00. With ZERO_IDLE=1, bo=0 before and after the handshake.
- Exhaustive: all 256 x, with si1 random, si0=x^si1, r random each run -> bo1^bo0 = S8inv(x). Spot values: 0x4c->0x01, 0x6a->0x02, 0xFF->0xFF.
- Round trip: forward masked sbox8 output fed to this block -> original plaintext byte recovered for all 256 values.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> bo1/bo0 and out_valid stable; in_ready=0 throughout; in_valid pulses ignored.
- Input instability: si1/si0/r toggled randomly every cycle after the accept edge -> result equals S8inv of the captured value.
- Reset mid-run: rst pulsed during L2 -> out_valid stays 0, in_ready=1 next cycle; the next transaction (0x00 -> 0x65's inverse check: input 0x65 gives 0x00) is correct.
